// File: rtl/mac_result_drain.sv
// Snapshots the MAC accumulators on capture, requantizes them (shift + signed saturate)
// and drains the results one per valid/ready handshake while the array keeps working.
module mac_result_drain #(
    parameter int unsigned N_MACS = 4,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SHIFT  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture,
    input  logic [N_MACS*ACC_W-1:0]   acc_in,
    output logic [N_MACS-1:0]         clear,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(N_MACS)-1:0] out_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned IdxW = $clog2(N_MACS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_MACS - 1);

    // Saturation bounds expressed at accumulator width so the compare stays signed.
    localparam logic signed [ACC_W-1:0] SatMax =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [OUT_W-1:0]    shadow_q [N_MACS];
    logic [OUT_W-1:0]    shadow_d [N_MACS];
    logic [N_MACS-1:0]   clear_q, clear_d;
    logic                overrun_q, overrun_d;

    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] s;
        s = x >>> SHIFT;
        if (s > SatMax) begin
            return SatMax[OUT_W-1:0];
        end else if (s < SatMin) begin
            return SatMin[OUT_W-1:0];
        end
        return s[OUT_W-1:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        clear_d   = '0;
        overrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    for (int unsigned i = 0; i < N_MACS; i++) begin
                        shadow_d[i] = requant(acc_in[i*ACC_W +: ACC_W]);
                    end
                    idx_d   = '0;
                    clear_d = '1;
                    state_d = StSend;
                end
            end
            StSend: begin
                // A capture here is dropped; only the overrun flag records it.
                overrun_d = capture;
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            clear_q   <= '0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < N_MACS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            clear_q   <= clear_d;
            overrun_q <= overrun_d;
            shadow_q  <= shadow_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StSend);
        busy      = out_valid;
        out_last  = out_valid && (idx_q == LastIdx);
        out_idx   = out_valid ? idx_q : '0;
        out_data  = out_valid ? shadow_q[idx_q] : '0;
        clear     = clear_q;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: fixed vector table, directed corner sequences
// and randomized drains checked against an arithmetic requantization model.
module tb_mac_result_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture;
    logic [63:0] acc_in;
    logic [3:0]  clear;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    mac_result_drain #(
        .N_MACS(4),
        .ACC_W (16),
        .OUT_W (8),
        .SHIFT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .acc_in   (acc_in),
        .clear    (clear),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] acc;  // MAC3..MAC0
        logic [31:0] exp;  // expected bytes, idx3..idx0
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: floor-divide by 2^4, clamp to the signed 8-bit range.
    function automatic logic [7:0] ref_q(input logic [15:0] a);
        int v;
        v = int'($signed(a));
        v = v >>> 4;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic logic [31:0] ref_all(input logic [63:0] acc);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = ref_q(acc[i*16 +: 16]);
        return r;
    endfunction

    task automatic do_capture(input logic [63:0] acc);
        capture = 1'b1;
        acc_in  = acc;
        tick();
        capture = 1'b0;
        acc_in  = ~acc;  // later changes must not reach the shadow registers
    endtask

    // Drain four results; random_ready=1 inserts random backpressure.
    task automatic drain(input logic [31:0] exp, input bit random_ready, input string tag);
        int k = 0;
        int cycles = 0;
        logic [7:0] prev_data;
        bit stalled = 1'b0;
        while (k < 4 && cycles < 200) begin
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            check({tag, " valid"}, 32'(out_valid), 32'd1);
            check({tag, " idx"}, 32'(out_idx), 32'(k));
            check({tag, " data"}, 32'(out_data), 32'(exp[k*8 +: 8]));
            check({tag, " last"}, 32'(out_last), 32'(k == 3));
            if (stalled) check({tag, " stable"}, 32'(out_data), 32'(prev_data));
            prev_data = out_data;
            stalled   = !out_ready;
            if (out_ready) k++;
            tick();
            cycles++;
        end
        if (k < 4) check({tag, " timeout"}, 32'(k), 32'd4);
        out_ready = 1'b1;
        check({tag, " end valid"}, 32'(out_valid), 32'd0);
        check({tag, " end busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [6:0]  pat;
        logic [63:0] acc;
        logic [31:0] exp;
        int hs;

        vecs[0] = '{acc: 64'h0005_7FFF_FF00_0100, exp: 32'h00_7F_F0_10};
        vecs[1] = '{acc: 64'h07F0_F801_FFFF_8000, exp: 32'h7F_80_FF_80};
        vecs[2] = '{acc: 64'h0800_F7F0_0010_0000, exp: 32'h7F_80_01_00};
        vecs[3] = '{acc: 64'hFFF0_000F_8001_7FF0, exp: 32'hFF_00_80_7F};

        rst = 1'b0; capture = 1'b1; acc_in = 64'h1234_5678_9ABC_DEF0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst clear", 32'(clear), 32'd0);
            check("rst valid", 32'(out_valid), 32'd0);
            check("rst busy", 32'(busy), 32'd0);
            check("rst overrun", 32'(overrun), 32'd0);
            check("rst data", 32'(out_data), 32'd0);
            check("rst idx", 32'(out_idx), 32'd0);
            check("rst last", 32'(out_last), 32'd0);
        end
        rst = 1'b1; capture = 1'b0;
        tick();
        check("post-rst busy", 32'(busy), 32'd0);

        // Table vectors, full-rate drain with clear pulse check.
        foreach (vecs[v]) begin
            do_capture(vecs[v].acc);
            check("clear pulse", 32'(clear), 32'hF);
            check("busy", 32'(busy), 32'd1);
            out_ready = 1'b1;
            tick();
            check("clear once", 32'(clear), 32'd0);
            check("idx1", 32'(out_idx), 32'd1);
            check("data1", 32'(out_data), 32'(vecs[v].exp[15:8]));
            tick();
            tick();
            check("last", 32'(out_last), 32'd1);
            check("data3", 32'(out_data), 32'(vecs[v].exp[31:24]));
            tick();
            check("done busy", 32'(busy), 32'd0);
            check("done valid", 32'(out_valid), 32'd0);
        end

        // Fixed backpressure pattern 1,0,0,1,0,1,1.
        do_capture(vecs[0].acc);
        pat = 7'b1101001;  // bit j = ready in cycle j
        hs = 0;
        for (int j = 0; j < 7; j++) begin
            out_ready = pat[j];
            check("bp idx", 32'(out_idx), 32'(hs));
            check("bp data", 32'(out_data), 32'(vecs[0].exp[hs*8 +: 8]));
            if (out_valid && out_ready) hs++;
            tick();
        end
        check("bp handshakes", 32'(hs), 32'd4);
        check("bp idle", 32'(busy), 32'd0);
        out_ready = 1'b1;

        // Overrun during a stall and on the last-handshake cycle.
        do_capture(vecs[1].acc);
        out_ready = 1'b0;
        capture = 1'b1; acc_in = vecs[0].acc;
        tick();
        capture = 1'b0;
        check("ovr pulse", 32'(overrun), 32'd1);
        check("ovr no clear", 32'(clear), 32'd0);
        check("ovr shadow", 32'(out_data), 32'(vecs[1].exp[7:0]));
        tick();
        check("ovr one cycle", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("ovr at last", 32'(out_last), 32'd1);
        check("ovr last data", 32'(out_data), 32'(vecs[1].exp[31:24]));
        capture = 1'b1;
        tick();
        capture = 1'b0;
        check("ovr2 pulse", 32'(overrun), 32'd1);
        check("ovr2 no clear", 32'(clear), 32'd0);
        check("ovr2 idle", 32'(busy), 32'd0);
        tick();
        check("ovr2 one cycle", 32'(overrun), 32'd0);
        check("ovr2 no start", 32'(busy), 32'd0);

        // Mid-drain reset after the second handshake.
        do_capture(vecs[2].acc);
        tick(); tick();
        check("mid idx2", 32'(out_idx), 32'd2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid valid", 32'(out_valid), 32'd0);
        check("mid busy", 32'(busy), 32'd0);
        check("mid idx", 32'(out_idx), 32'd0);
        tick();
        check("mid stays idle", 32'(busy), 32'd0);
        do_capture(vecs[3].acc);
        drain(vecs[3].exp, 1'b0, "restart");

        // Randomized drains against the model.
        for (int r = 0; r < 20; r++) begin
            acc = {$urandom(), $urandom()};
            exp = ref_all(acc);
            do_capture(acc);
            drain(exp, 1'b1, "rand");
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
